// File: rtl/mult_pkg.sv
// Shared definitions for the seq_mult_n sequential multiplier.
// Holds the one-hot state bit indices, the one-hot state encoding,
// and a constant clog2 helper used to size the bit counter.
package mult_pkg;

  // Bit position of each state inside the one-hot state vector.
  localparam int S_IDLE   = 0;
  localparam int S_ADD    = 1;
  localparam int S_SHIFT  = 2;
  localparam int S_FIX    = 3;
  localparam int S_DONE   = 4;
  localparam int N_STATES = 5;

  // One-hot encodings; each value sets exactly the bit named by its index.
  typedef enum logic [N_STATES-1:0] {
    ST_IDLE  = N_STATES'(32'd1 << S_IDLE),
    ST_ADD   = N_STATES'(32'd1 << S_ADD),
    ST_SHIFT = N_STATES'(32'd1 << S_SHIFT),
    ST_FIX   = N_STATES'(32'd1 << S_FIX),
    ST_DONE  = N_STATES'(32'd1 << S_DONE)
  } state_e;

  // Smallest r such that 2**r >= value (constant-evaluable).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_mult_n_ctrl.sv
// One-hot control FSM for seq_mult_n.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start           : multiply request (honoured only in IDLE)
//   p_zero          : bit counter has reached zero
//   q0              : current LSB of the multiplier register
//   out_ready       : consumer accepts the product (honoured only in DONE)
//   load_regs       : IDLE & start, load operands on this edge
//   add_regs        : ADD & q0, accumulate B into {C,A}
//   decr_p          : in ADD, decrement bit counter
//   shift_regs      : in SHIFT, shift {C,A,Q} right
//   fix             : in FIX, write the sign-corrected product
//   ready/busy/out_valid : status decoded straight from the state flops
module seq_mult_n_ctrl
  import mult_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic p_zero,
  input  logic q0,
  input  logic out_ready,
  output logic load_regs,
  output logic add_regs,
  output logic decr_p,
  output logic shift_regs,
  output logic fix,
  output logic ready,
  output logic busy,
  output logic out_valid
);

  state_e state_q;
  state_e state_d;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and Mealy strobes.
  always_comb begin
    state_d   = state_q;
    load_regs = 1'b0;
    add_regs  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ADD;
          load_regs = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADD: begin
        state_d  = ST_SHIFT;
        add_regs = q0;
      end
      ST_SHIFT: begin
        if (p_zero) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_ADD;
        end
      end
      ST_FIX: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      // Any non-one-hot value recovers to IDLE.
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore outputs come directly from individual state flops.
  assign decr_p     = state_q[S_ADD];
  assign shift_regs = state_q[S_SHIFT];
  assign fix        = state_q[S_FIX];
  assign ready      = state_q[S_IDLE];
  assign busy       = state_q[S_ADD] | state_q[S_SHIFT] | state_q[S_FIX];
  assign out_valid  = state_q[S_DONE];

endmodule

// File: rtl/seq_mult_n.sv
// Parametrised sequential shift-add multiplier, signed or unsigned.
// Operands are converted to magnitudes on load, multiplied with WIDTH
// add/shift rounds, and the sign is applied in a single fix-up cycle, so
// latency is the same for every operand pair and mode.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   start, is_signed        : request and mode, sampled only when ready
//   multiplicand, multiplier: WIDTH-bit operands B and Q
//   ready, busy, out_valid  : status
//   out_ready               : consumer handshake for the held product
//   product                 : 2*WIDTH-bit result
module seq_mult_n
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = clog2(WIDTH + 1);

  logic [WIDTH-1:0]   a_q, a_d, q_q, q_d, b_q, b_d;
  logic               c_q, c_d, neg_q, neg_d;
  logic [CNT_W-1:0]   p_q, p_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic load_regs, add_regs, decr_p, shift_regs, fix;
  logic p_zero;

  logic [WIDTH-1:0]   mcand_mag, mplier_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_mag, prod_neg;

  seq_mult_n_ctrl u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .p_zero     (p_zero),
    .q0         (q_q[0]),
    .out_ready  (out_ready),
    .load_regs  (load_regs),
    .add_regs   (add_regs),
    .decr_p     (decr_p),
    .shift_regs (shift_regs),
    .fix        (fix),
    .ready      (ready),
    .busy       (busy),
    .out_valid  (out_valid)
  );

  // Magnitudes: -2**(WIDTH-1) negates to itself, which is the correct
  // unsigned magnitude in WIDTH bits.
  assign mcand_mag  = (is_signed && multiplicand[WIDTH-1]) ? (~multiplicand + WIDTH'(1)) : multiplicand;
  assign mplier_mag = (is_signed && multiplier[WIDTH-1])   ? (~multiplier + WIDTH'(1))   : multiplier;

  // Carry-preserving adder; C holds bit WIDTH so max*max stays exact.
  assign sum      = {1'b0, a_q} + {1'b0, b_q};
  assign prod_mag = {a_q, q_q};
  assign prod_neg = ~prod_mag + (2*WIDTH)'(1);
  assign p_zero   = (p_q == {CNT_W{1'b0}});

  // Datapath next-state.
  always_comb begin
    a_d       = a_q;
    q_d       = q_q;
    b_d       = b_q;
    c_d       = c_q;
    p_d       = p_q;
    neg_d     = neg_q;
    product_d = product_q;
    if (load_regs) begin
      a_d   = {WIDTH{1'b0}};
      c_d   = 1'b0;
      b_d   = mcand_mag;
      q_d   = mplier_mag;
      p_d   = CNT_W'(WIDTH);
      neg_d = is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
    end else begin
      if (add_regs) begin
        {c_d, a_d} = sum;
      end else begin
        c_d = c_q;
      end
      if (decr_p) begin
        p_d = p_q - CNT_W'(1);
      end else begin
        p_d = p_q;
      end
      if (shift_regs) begin
        // {C,A,Q} >> 1 with zero shifted into C.
        a_d = {c_q, a_q[WIDTH-1:1]};
        q_d = {a_q[0], q_q[WIDTH-1:1]};
        c_d = 1'b0;
      end else begin
        q_d = q_q;
      end
      if (fix) begin
        product_d = neg_q ? prod_neg : prod_mag;
      end else begin
        product_d = product_q;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= {WIDTH{1'b0}};
      q_q       <= {WIDTH{1'b0}};
      b_q       <= {WIDTH{1'b0}};
      c_q       <= 1'b0;
      p_q       <= {CNT_W{1'b0}};
      neg_q     <= 1'b0;
      product_q <= {(2*WIDTH){1'b0}};
    end else begin
      a_q       <= a_d;
      q_q       <= q_d;
      b_q       <= b_d;
      c_q       <= c_d;
      p_q       <= p_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_seq_mult_n.sv
// Self-checking bench for seq_mult_n at WIDTH = 8, 4 and 16.
module tb_seq_mult_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // WIDTH=8 instance
  logic        start, is_signed, out_ready, ready, busy, out_valid;
  logic [7:0]  mcand, mplier;
  logic [15:0] product;
  // WIDTH=4 instance
  logic        st4, sg4, or4, rd4, bz4, ov4;
  logic [3:0]  b4, q4;
  logic [7:0]  p4;
  // WIDTH=16 instance
  logic        st16, sg16, or16, rd16, bz16, ov16;
  logic [15:0] b16, q16;
  logic [31:0] p16;

  seq_mult_n #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .multiplicand(mcand), .multiplier(mplier), .ready(ready), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .product(product));

  seq_mult_n #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(st4), .is_signed(sg4),
    .multiplicand(b4), .multiplier(q4), .ready(rd4), .busy(bz4),
    .out_valid(ov4), .out_ready(or4), .product(p4));

  seq_mult_n #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(st16), .is_signed(sg16),
    .multiplicand(b16), .multiplier(q16), .ready(rd16), .busy(bz16),
    .out_valid(ov16), .out_ready(or16), .product(p16));

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference product: plain integer multiply, wrapped to 2*w bits.
  function automatic logic [63:0] ref_mul(input int w, input logic s,
                                          input logic [31:0] b, input logic [31:0] q);
    longint bb, qq, r;
    bb = longint'({32'd0, b});
    qq = longint'({32'd0, q});
    if (s && b[w-1]) bb = bb - (64'sd1 <<< w);
    if (s && q[w-1]) qq = qq - (64'sd1 <<< w);
    r = bb * qq;
    return 64'(r) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // Transaction-level model of the WIDTH=8 unit: idle / busy for a fixed
  // number of cycles / holding a result until the consumer takes it.
  typedef enum int {M_IDLE, M_BUSY, M_DONE} mphase_e;
  mphase_e     m_phase = M_IDLE;
  int          m_cnt = 0;
  logic [15:0] m_pend = 16'd0;
  logic [15:0] m_prod = 16'd0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase <= M_IDLE;
      m_cnt   <= 0;
      m_prod  <= 16'd0;
    end else begin
      case (m_phase)
        M_IDLE: if (start) begin
          m_phase <= M_BUSY;
          m_cnt   <= 0;
          m_pend  <= 16'(ref_mul(8, is_signed, 32'(mcand), 32'(mplier)));
        end
        M_BUSY: begin
          m_cnt <= m_cnt + 1;
          if (m_cnt + 1 == 17) begin
            m_phase <= M_DONE;
            m_prod  <= m_pend;
          end
        end
        default: if (out_ready) m_phase <= M_IDLE;
      endcase
    end
  end

  // Cycle-by-cycle comparison of the WIDTH=8 unit against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_ready", 64'(ready), 64'(m_phase == M_IDLE));
      check("cyc_busy", 64'(busy), 64'(m_phase == M_BUSY));
      check("cyc_out_valid", 64'(out_valid), 64'(m_phase == M_DONE));
      check("cyc_product", 64'(product), 64'(m_prod));
    end
  end

  function automatic logic dut_valid(input int w);
    case (w)
      4:       return ov4;
      16:      return ov16;
      default: return out_valid;
    endcase
  endfunction

  function automatic logic dut_ready(input int w);
    case (w)
      4:       return rd4;
      16:      return rd16;
      default: return ready;
    endcase
  endfunction

  function automatic logic [63:0] dut_prod(input int w);
    case (w)
      4:       return 64'(p4);
      16:      return 64'(p16);
      default: return 64'(product);
    endcase
  endfunction

  // One multiply on the selected instance: latency, product, return to idle.
  task automatic run_op(input int w, input logic s, input logic [31:0] b,
                        input logic [31:0] q, input logic [63:0] exp, input string name);
    int k;
    @(negedge clk);
    case (w)
      4:  begin st4 = 1'b1; sg4 = s; b4 = b[3:0]; q4 = q[3:0]; end
      16: begin st16 = 1'b1; sg16 = s; b16 = b[15:0]; q16 = q[15:0]; end
      default: begin start = 1'b1; is_signed = s; mcand = b[7:0]; mplier = q[7:0]; end
    endcase
    @(negedge clk);
    st4 = 1'b0; st16 = 1'b0; start = 1'b0;
    k = 0;
    while (!dut_valid(w) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({name, "_latency"}, 64'(k), 64'(2 * w + 1));
    check({name, "_product"}, dut_prod(w), exp);
    if (w != 8 || out_ready) begin
      @(negedge clk);
      check({name, "_ready_after"}, 64'(dut_ready(w)), 64'd1);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; is_signed = 1'b0; mcand = 8'd0; mplier = 8'd0; out_ready = 1'b1;
    st4 = 1'b0; sg4 = 1'b0; b4 = 4'd0; q4 = 4'd0; or4 = 1'b1;
    st16 = 1'b0; sg16 = 1'b0; b16 = 16'd0; q16 = 16'd0; or16 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    // WIDTH=8 directed vectors with hand-computed products.
    run_op(8, 1'b0, 32'd13,   32'd11,   64'd143,     "u13x11");
    run_op(8, 1'b1, 32'hFD,   32'd5,    64'hFFF1,    "s_m3x5");
    run_op(8, 1'b1, 32'h80,   32'h80,   64'h4000,    "s_m128sq");
    run_op(8, 1'b0, 32'd255,  32'd255,  64'hFE01,    "u255sq");
    run_op(8, 1'b0, 32'd0,    32'd200,  64'd0,       "u0x200");
    run_op(8, 1'b1, 32'd0,    32'hF9,   64'd0,       "s0xm7");
    run_op(8, 1'b1, 32'h7F,   32'h80,   64'hC080,    "s127xm128");
    run_op(8, 1'b1, 32'hFF,   32'hFF,   64'h0001,    "s_m1sq");

    // Hold the result in DONE while start pulses and operands change.
    out_ready = 1'b0;
    run_op(8, 1'b0, 32'd12, 32'd12, 64'd144, "hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = ~start;
      mcand = 8'($urandom);
      mplier = 8'($urandom);
      is_signed = ~is_signed;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_product", 64'(product), 64'd144);
    end
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_release_ready", 64'(ready), 64'd1);
    check("hold_release_valid", 64'(out_valid), 64'd0);

    // Reset in the middle of a 7*9 operation.
    start = 1'b1; is_signed = 1'b0; mcand = 8'd7; mplier = 8'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_product", 64'(product), 64'd0);
    run_op(8, 1'b0, 32'd2, 32'd3, 64'd6, "post_abort_2x3");

    // A few random WIDTH=8 operations, checked cycle by cycle by the model.
    for (int i = 0; i < 6; i++) begin
      logic s;
      logic [31:0] b, q;
      s = 1'($urandom_range(0, 1));
      b = 32'($urandom_range(0, 255));
      q = 32'($urandom_range(0, 255));
      run_op(8, s, b, q, ref_mul(8, s, b, q), "w8_rand");
    end

    // WIDTH=4 directed vectors.
    run_op(4, 1'b0, 32'd15, 32'd15, 64'd225,  "w4_u15sq");
    run_op(4, 1'b1, 32'd8,  32'd7,  64'hC8,   "w4_s_m8x7");
    run_op(4, 1'b1, 32'hF,  32'hF,  64'h01,   "w4_s_m1sq");

    // WIDTH=16 corners and random sweep.
    run_op(16, 1'b0, 32'hFFFF, 32'hFFFF, 64'hFFFE0001, "w16_umax");
    run_op(16, 1'b1, 32'h8000, 32'h8000, 64'h40000000, "w16_sminsq");
    for (int i = 0; i < 20; i++) begin
      logic s;
      logic [31:0] b, q;
      s = 1'($urandom_range(0, 1));
      b = 32'($urandom_range(0, 65535));
      q = 32'($urandom_range(0, 65535));
      run_op(16, s, b, q, ref_mul(16, s, b, q), "w16_rand");
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
